fetch_ctrl: RTL

//   Sequencer for the instruction-fetch stage. Owns the PC register and drives the instruction-memory port.

---
 rtl/fetch_pkg.sv | 7 +
 rtl/fetch_watchdog.sv | 17 +
 rtl/fetch_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction-fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, HOLD, ERROR} fetch_state_t;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts consecutive FETCH cycles without imem_ready and flags a timeout.
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic timeout_o
);
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  assign cnt_d = en_i ? cnt_q + 8'd1 : 8'd0;
  assign timeout_o = en_i && cnt_q == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC, instruction-memory request sequencing and IF/ID register.
// Define FETCH_TIMEOUT_EN to enable the imem_ready watchdog and sticky fetch_err.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          BOOT_CYCLES    = 4,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               EX_MEM_PCsrc,
  input  logic [31:0]        EX_MEM_NPC,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] IF_ID_instr,
  output logic [31:0]        IF_ID_npc,
  output logic               IF_ID_valid,
  output logic               fetch_err
);
  if (BOOT_CYCLES < 1 || BOOT_CYCLES > 255) begin : g_bad_boot
    $error("BOOT_CYCLES out of range");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end
  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [7:0]         boot_q, boot_d;
  logic [INSTR_W-1:0] hold_q, hold_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        npc_q, npc_d;
  logic               valid_q, valid_d;
  logic [31:0]        pc_inc, redirect_pc;
  logic               timeout;
  assign pc_inc      = pc_q + PC_STEP;
  assign redirect_pc = EX_MEM_NPC & ~32'd3;
  // Request is purely a function of state so an async reset drops it immediately.
  assign imem_req    = state_q == FETCH;
  assign imem_addr   = pc_q;
  assign IF_ID_instr = instr_q;
  assign IF_ID_npc   = npc_q;
  assign IF_ID_valid = valid_q;
`ifdef FETCH_TIMEOUT_EN
  logic err_q;
  fetch_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk      (clk),
    .reset    (reset),
    .en_i     (state_q == FETCH && !imem_ready && !EX_MEM_PCsrc),
    .timeout_o(timeout)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) err_q <= 1'b0;
    else err_q <= err_q | timeout;
  assign fetch_err = err_q;
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    boot_d  = boot_q;
    hold_d  = hold_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    case (state_q)
      BOOT: begin
        boot_d  = boot_q + 8'd1;
        state_d = boot_q == 8'(BOOT_CYCLES - 1) ? FETCH : BOOT;
      end
      FETCH: begin
        if (EX_MEM_PCsrc) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (timeout) begin
          state_d = ERROR;
          valid_d = 1'b0;
        end else if (imem_ready && !stall) begin
          instr_d = imem_rdata;
          npc_d   = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
        end else if (imem_ready) begin
          hold_d  = imem_rdata;
          state_d = HOLD;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (EX_MEM_PCsrc) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (!stall) begin
          instr_d = hold_q;
          npc_d   = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      default: valid_d = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      boot_q  <= '0;
      hold_q  <= NOP_INSTR;
      instr_q <= NOP_INSTR;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      boot_q  <= boot_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
endmodule
